// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the gpio_irq peripheral: register map and pin-count checks.
package gpio_irq_pkg;

  localparam logic [7:0] OFS_DIR        = 8'h00;
  localparam logic [7:0] OFS_OUT        = 8'h04;
  localparam logic [7:0] OFS_IN         = 8'h08;
  localparam logic [7:0] OFS_OUT_SET    = 8'h0C;
  localparam logic [7:0] OFS_OUT_CLR    = 8'h10;
  localparam logic [7:0] OFS_OUT_TGL    = 8'h14;
  localparam logic [7:0] OFS_RISE_EN    = 8'h18;
  localparam logic [7:0] OFS_FALL_EN    = 8'h1C;
  localparam logic [7:0] OFS_IRQ_STATUS = 8'h20;
  localparam logic [7:0] OFS_DEB_CFG    = 8'h24;

  // Every pin vector must fit in one 32-bit register.
  function automatic bit pins_fit(input int num_bidir, input int num_other);
    return (num_bidir >= 1) && (num_bidir <= 32) && (num_other >= 0) &&
           (num_bidir + num_other <= 32);
  endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Input conditioning: SYNC_STAGES-deep synchroniser followed by a tick-based debounce.
// A bit propagates to filt only when it reads the same on two consecutive prescaler ticks.
module gpio_in_filter
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [DEB_W-1:0] deb_cfg,
  input  logic             deb_cfg_wr,
  output logic [WIDTH-1:0] filt
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]                  cnt_q, cnt_d;
  logic [WIDTH-1:0]                  sample_q, sample_d;
  logic [WIDTH-1:0]                  filt_q, filt_d;
  logic [WIDTH-1:0]                  sync_out;
  logic [WIDTH-1:0]                  agree;
  logic                              tick;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pin_in};
    sync_out = sync_q[SYNC_STAGES-1];
    tick     = (deb_cfg != '0) && (cnt_q == deb_cfg);
    agree    = ~(sync_out ^ sample_q);

    if (deb_cfg_wr || (deb_cfg == '0) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    sample_d = tick ? sync_out : sample_q;

    // Only bits that matched the previous tick's sample are allowed through.
    if (deb_cfg == '0) begin
      filt_d = sync_out;
    end else if (tick) begin
      filt_d = (filt_q & ~agree) | (sync_out & agree);
    end else begin
      filt_d = filt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      filt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      filt_q   <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral: register file with atomic set/clear/toggle, filtered inputs,
// per-pin rise/fall capture into RW1C status and a registered level interrupt.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter logic [31:0] GPIO_BASE_ADDR = 32'h4000_1000,
  parameter int          NUM_BIDIR      = 4,
  parameter int          NUM_OUT        = 6,
  parameter int          NUM_IN         = 6,
  parameter int          SYNC_STAGES    = 2,
  parameter int          DEB_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic                 mem_we,
  input  logic                 mem_re,
  output logic [31:0]          mem_rdata,
  input  logic [NUM_BIDIR-1:0] gpio_bidir_in,
  output logic [NUM_BIDIR-1:0] gpio_bidir_out,
  output logic [NUM_BIDIR-1:0] gpio_bidir_oe,
  output logic [NUM_OUT-1:0]   gpio_out,
  input  logic [NUM_IN-1:0]    gpio_in,
  output logic                 irq
);

  localparam int OUT_W = NUM_BIDIR + NUM_OUT;
  localparam int IN_W  = NUM_BIDIR + NUM_IN;

  if (!pins_fit(NUM_BIDIR, NUM_OUT) || !pins_fit(NUM_BIDIR, NUM_IN) ||
      (SYNC_STAGES < 2) || (DEB_W < 1) || (DEB_W > 32)) begin : g_bad_params
    $error("gpio_irq: pin counts or filter parameters out of range");
  end

  logic [NUM_BIDIR-1:0] dir_q, dir_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [IN_W-1:0]      rise_en_q, rise_en_d;
  logic [IN_W-1:0]      fall_en_q, fall_en_d;
  logic [IN_W-1:0]      irq_status_q, irq_status_d;
  logic [DEB_W-1:0]     deb_cfg_q, deb_cfg_d;
  logic [IN_W-1:0]      filt_prev_q, filt_prev_d;
  logic                 irq_q, irq_d;

  logic                 sel, wr;
  logic [7:0]           ofs;
  logic [IN_W-1:0]      filt, w1c, rise, fall;
  logic                 deb_cfg_wr;
  logic                 unused_wdata;

  assign unused_wdata = ^mem_wdata;

  assign sel        = (mem_addr[31:8] == GPIO_BASE_ADDR[31:8]);
  assign wr         = sel && mem_we;
  assign ofs        = mem_addr[7:0];
  assign deb_cfg_wr = wr && (ofs == OFS_DEB_CFG);

  gpio_in_filter #(
    .WIDTH       (IN_W),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_W       (DEB_W)
  ) u_in_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_in     ({gpio_in, gpio_bidir_in}),
    .deb_cfg    (deb_cfg_q),
    .deb_cfg_wr (deb_cfg_wr),
    .filt       (filt)
  );

  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_cfg_d = deb_cfg_q;
    w1c       = '0;

    if (wr) begin
      case (ofs)
        OFS_DIR:        dir_d     = mem_wdata[NUM_BIDIR-1:0];
        OFS_OUT:        out_d     = mem_wdata[OUT_W-1:0];
        OFS_OUT_SET:    out_d     = out_q | mem_wdata[OUT_W-1:0];
        OFS_OUT_CLR:    out_d     = out_q & ~mem_wdata[OUT_W-1:0];
        OFS_OUT_TGL:    out_d     = out_q ^ mem_wdata[OUT_W-1:0];
        OFS_RISE_EN:    rise_en_d = mem_wdata[IN_W-1:0];
        OFS_FALL_EN:    fall_en_d = mem_wdata[IN_W-1:0];
        OFS_IRQ_STATUS: w1c       = mem_wdata[IN_W-1:0];
        OFS_DEB_CFG:    deb_cfg_d = mem_wdata[DEB_W-1:0];
        default: ;
      endcase
    end

    filt_prev_d  = filt;
    rise         = filt & ~filt_prev_q;
    fall         = ~filt & filt_prev_q;
    // New events are ORed in after the clear so a coincident edge is never lost.
    irq_status_d = (irq_status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d        = |irq_status_q;
  end

  always_comb begin
    mem_rdata = '0;
    if (sel && mem_re) begin
      case (ofs)
        OFS_DIR:        mem_rdata = 32'(dir_q);
        OFS_OUT:        mem_rdata = 32'(out_q);
        OFS_IN:         mem_rdata = 32'(filt);
        OFS_RISE_EN:    mem_rdata = 32'(rise_en_q);
        OFS_FALL_EN:    mem_rdata = 32'(fall_en_q);
        OFS_IRQ_STATUS: mem_rdata = 32'(irq_status_q);
        OFS_DEB_CFG:    mem_rdata = 32'(deb_cfg_q);
        default:        mem_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= '0;
      out_q        <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
      deb_cfg_q    <= '0;
      filt_prev_q  <= '0;
      irq_q        <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      out_q        <= out_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_status_q <= irq_status_d;
      deb_cfg_q    <= deb_cfg_d;
      filt_prev_q  <= filt_prev_d;
      irq_q        <= irq_d;
    end
  end

  assign gpio_bidir_out = out_q[NUM_BIDIR-1:0];
  assign gpio_out       = out_q[OUT_W-1:NUM_BIDIR];
  assign gpio_bidir_oe  = dir_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed-vector bench for gpio_irq with hand-computed expectations.
module tb_gpio_irq;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [3:0]  gbi, gpio_bidir_out, gpio_bidir_oe;
  logic [5:0]  gin, gpio_out;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_irq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata),
    .gpio_bidir_in  (gbi),
    .gpio_bidir_out (gpio_bidir_out),
    .gpio_bidir_oe  (gpio_bidir_oe),
    .gpio_out       (gpio_out),
    .gpio_in        (gin),
    .irq            (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_abs(input logic [31:0] addr, input logic [31:0] d);
    mem_addr  = addr;
    mem_wdata = d;
    mem_we    = 1'b1;
    @(negedge clk);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
    wr_abs(BASE | 32'(ofs), d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    mem_re   = 1'b1;
    #1;
    chk(tag, mem_rdata, exp);
    mem_re   = 1'b0;
    mem_addr = '0;
  endtask

  initial begin
    mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
    rst_n = 1'b0; gbi = 4'hF; gin = 6'h3F;
    step(2);

    // Reset state with all pins high
    chk("rst_irq", 32'(irq), 0);
    chk("rst_bidir_out", 32'(gpio_bidir_out), 0);
    chk("rst_oe", 32'(gpio_bidir_oe), 0);
    chk("rst_gpio_out", 32'(gpio_out), 0);
    rd_chk("rst_status", BASE + 32'h20, 0);
    rst_n = 1'b1;
    step(3);
    rd_chk("in_all_ones", BASE + 32'h08, 32'h3FF);
    rd_chk("status_after_rst", BASE + 32'h20, 0);
    chk("irq_after_rst", 32'(irq), 0);

    // Output register and atomic access
    wr(8'h00, 32'hFFFF_FFF5);
    rd_chk("dir_masked", BASE + 32'h00, 32'h5);
    chk("oe", 32'(gpio_bidir_oe), 32'h5);
    wr(8'h04, 32'h05);
    wr(8'h0C, 32'h0A);
    wr(8'h10, 32'h01);
    wr(8'h14, 32'h30);
    rd_chk("out_val", BASE + 32'h04, 32'h3E);
    chk("bidir_out", 32'(gpio_bidir_out), 32'hE);
    chk("gpio_out", 32'(gpio_out), 32'h3);
    rd_chk("set_reads0", BASE + 32'h0C, 0);
    rd_chk("tgl_reads0", BASE + 32'h14, 0);

    // Falls with edges disabled, then enabling is not retroactive
    gin = 6'h00; gbi = 4'h0;
    step(5);
    rd_chk("fall_discarded", BASE + 32'h20, 0);
    wr(8'h18, 32'h10);
    rd_chk("no_retro", BASE + 32'h20, 0);

    // Rise latency on gpio_in[0] (vector bit 4)
    gin[0] = 1'b1;
    step(2);
    rd_chk("in_n1", BASE + 32'h08, 32'h000);
    step(1);
    rd_chk("in_n2", BASE + 32'h08, 32'h010);
    rd_chk("status_n2", BASE + 32'h20, 0);
    step(1);
    rd_chk("status_n3", BASE + 32'h20, 32'h10);
    chk("irq_n3", 32'(irq), 0);
    step(1);
    chk("irq_n4", 32'(irq), 1);

    // W1C coincident with a new rise: event wins
    gin[0] = 1'b0;
    step(5);
    rd_chk("status_hold", BASE + 32'h20, 32'h10);
    gin[0] = 1'b1;
    step(3);
    wr(8'h20, 32'h10);
    rd_chk("w1c_race", BASE + 32'h20, 32'h10);
    chk("irq_race", 32'(irq), 1);
    step(1);
    chk("irq_race2", 32'(irq), 1);

    // Plain W1C: irq falls one edge later
    wr(8'h20, 32'hFFFF_FFFF);
    rd_chk("w1c_clear", BASE + 32'h20, 0);
    chk("irq_w1c_edge", 32'(irq), 1);
    step(1);
    chk("irq_w1c_next", 32'(irq), 0);

    // Falling edge on bidir[0]; disabling does not clear status
    wr(8'h1C, 32'h01);
    gbi[0] = 1'b1;
    step(5);
    rd_chk("fall_rise_ignored", BASE + 32'h20, 0);
    gbi[0] = 1'b0;
    step(5);
    rd_chk("fall_status", BASE + 32'h20, 32'h01);
    chk("fall_irq", 32'(irq), 1);
    wr(8'h1C, 32'h00);
    rd_chk("disable_keeps", BASE + 32'h20, 32'h01);
    wr(8'h20, 32'h01);
    step(1);
    chk("fall_irq_clr", 32'(irq), 0);

    // Debounce D=3 on gpio_in[1] (vector bit 5)
    wr(8'h24, 32'h3);
    rd_chk("deb_cfg", BASE + 32'h24, 32'h3);
    gin[1] = 1'b1;
    step(3);
    gin[1] = 1'b0;
    step(12);
    rd_chk("glitch_rejected", BASE + 32'h08, 32'h010);
    gin[1] = 1'b1;
    step(4);
    rd_chk("deb_not_yet", BASE + 32'h08, 32'h010);
    step(6);
    rd_chk("deb_passed", BASE + 32'h08, 32'h030);

    // Unmapped offsets, read-only IN, foreign base
    wr(8'h28, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", BASE + 32'h28, 0);
    wr(8'h08, 32'h0);
    rd_chk("in_ro", BASE + 32'h08, 32'h030);
    wr_abs(32'h4000_2004, 32'h0);
    rd_chk("out_untouched", BASE + 32'h04, 32'h3E);
    rd_chk("other_base_rd", 32'h4000_2004, 0);
    mem_addr = BASE + 32'h04;
    #1;
    chk("no_re_zero", mem_rdata, 0);
    mem_addr = '0;

    // Mid-operation reset with pending status
    wr(8'h24, 32'h0);
    wr(8'h18, 32'h20);
    gin[1] = 1'b0;
    step(5);
    gin[1] = 1'b1;
    step(5);
    chk("pre_rst_irq", 32'(irq), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_gpio_out", 32'(gpio_out), 0);
    chk("mid_rst_oe", 32'(gpio_bidir_oe), 0);
    rd_chk("mid_rst_status", BASE + 32'h20, 0);
    rd_chk("mid_rst_in", BASE + 32'h08, 0);
    rd_chk("mid_rst_deb", BASE + 32'h24, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Second-generation GPIO peripheral on the memory-mapped peripheral bus at base 0x40001000. It adds to the first generation:
- parameterised bidir/out/in pin counts;
- a metastability synchroniser and programmable debounce filter on every input;
- atomic set/clear/toggle output access;
- per-pin rising/falling-edge interrupt capture with a single level interrupt to the core.

## Interface
- GPIO_BASE_ADDR, 32'h40001000, bus base; decode on mem_addr[31:8]
- NUM_BIDIR, 4, bidirectional pins (1..32)
- NUM_OUT, 6, output-only pins; NUM_BIDIR+NUM_OUT ≤ 32
- NUM_IN, 6, input-only pins; NUM_BIDIR+NUM_IN ≤ 32
- SYNC_STAGES, 2, synchroniser depth (≥2)
- DEB_W, 8, debounce prescaler width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_we  in  1  write strobe, one transaction per cycle
- mem_re  in  1  read strobe
- mem_rdata  out  32  combinational read data; 0 unless selected and mem_re
- gpio_bidir_in  in  NUM_BIDIR  asynchronous pad input
- gpio_bidir_out  out  NUM_BIDIR  OUT[NUM_BIDIR-1:0]
- gpio_bidir_oe  out  NUM_BIDIR  DIR (1 = drive)
- gpio_out  out  NUM_OUT  OUT[NUM_BIDIR+NUM_OUT-1:NUM_BIDIR]
- gpio_in  in  NUM_IN  asynchronous pad input
- irq  out  1  OR of IRQ_STATUS, registered source

## Operation
- Input vector order is {gpio_in, gpio_bidir_in}, bidir in the low bits. Output vector order is the same.
- Registers are word-aligned and decoded on mem_addr[7:0]. Unmapped offsets read 0 and ignore writes. Unused high bits read 0, and writes to them are ignored.
  - 0x00 DIR (RW)
  - 0x04 OUT (RW)
  - 0x08 IN (RO): filtered inputs
  - 0x0C OUT_SET (WO): W1S
  - 0x10 OUT_CLR (WO): W1C
  - 0x14 OUT_TGL (WO): write-1-toggle
  - 0x18 RISE_EN (RW)
  - 0x1C FALL_EN (RW)
  - 0x20 IRQ_STATUS (RW1C)
  - 0x24 DEB_CFG (RW, DEB_W bits)
- SET, CLR and TGL read 0. Bits written 0 leave OUT unchanged.
- Input path: SYNC_STAGES flops → debounce → filt register → IN.
  - DEB_CFG = 0: filt ← sync output every cycle.
  - DEB_CFG = D > 0: a prescaler counts 0..D and wraps, producing a tick when count == D (period D+1). On each tick, sample ← sync; filt bit ← sync bit only if sync bit == previous sample bit. An input must be equal on two consecutive ticks to propagate.
  - Any write to DEB_CFG clears the prescaler to 0.
- Edge detect: filt_d ← filt every cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - IRQ_STATUS ← (IRQ_STATUS & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - A new event in the same cycle as its W1C wins: the bit stays 1.
  - Enabling an edge never sets status retroactively. Disabling an edge does not clear status.
- irq ← |IRQ_STATUS (registered).

## Timing
- Reset values (all 0):
  - DIR, OUT, RISE_EN, FALL_EN, IRQ_STATUS, DEB_CFG
  - sync chain, sample, filt, filt_d, prescaler
  - irq, gpio_bidir_out, gpio_bidir_oe, gpio_out
- A pin high at reset release is seen as a rise; it is discarded because enables are 0.
- Register writes take effect at the clock edge with mem_we. Pad outputs change at that same edge. Reads are zero-latency and combinational.
- With DEB_CFG = 0, a pin level stable before edge N:
  - visible in IN after edge N+SYNC_STAGES;
  - sets IRQ_STATUS at edge N+SYNC_STAGES+1;
  - raises irq at edge N+SYNC_STAGES+2.
- With DEB_CFG = D, filt latency after the sync output changes is between D+1 and 2(D+1) cycles. A pulse not captured on two consecutive ticks is rejected.
- irq falls one edge after the W1C that clears the last status bit.
- rst_n asserted mid-operation clears everything immediately, including a debounce in progress and pending status.

## Structure
- Package gpio_irq_pkg holds:
  - register offset localparams (0x00–0x24);
  - the width-check macro or assertions for NUM_* ≤ 32.
- Sub-module gpio_in_filter, parameterised by WIDTH, SYNC_STAGES and DEB_W:
  - contains the synchroniser, prescaler, sample/filt registers and the DEB_CFG-write prescaler clear;
  - outputs filt.
- Top level holds the register file, set/clear/toggle logic, edge detect, status and irq.

## Test plan
- Reset with all pins high → all outputs 0, irq 0, IN reads all-ones after SYNC_STAGES+1 cycles, IRQ_STATUS reads 0.
- Write OUT=0x05, OUT_SET=0x0A, OUT_CLR=0x01, OUT_TGL=0x30 → OUT reads 0x3E; gpio_bidir_out=0xE; gpio_out=0x03.
- RISE_EN=0x10, DEB_CFG=0, gpio_in[0] 0→1 → IRQ_STATUS bit4 set at N+3, irq at N+4. W1C 0x10 → irq 0 next edge.
- W1C of bit4 in the same cycle as a new rise on that pin → bit4 remains 1, irq stays 1.
- DEB_CFG=3: a 3-cycle high glitch is rejected (IN unchanged). A level held for 8 cycles updates IN within 8 cycles of the sync output.
- Write to offset 0x28 and to IN → no register changes, reads return 0 and the unchanged IN respectively.
